// File: rtl/uart_rx_latch_if.sv
// Receive-side bus of the UART receiver: serial line and ack in, held byte and status out.
interface uart_rx_latch_if #(
    parameter int data_bits = 8
);
    logic                 uart_rxd;
    logic                 rx_ack;
    logic [data_bits-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output uart_rxd, rx_ack,
        input  rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
    );

    modport slave (
        input  uart_rxd, rx_ack,
        output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_rx_latch.sv
// 8N1 UART receiver with mid-bit sampling, a held output byte and a valid/ack handshake.
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on the synchronized line
// START     | half a bit period into the start bit, confirming it is still low
// DATA      | sampling data bits once per bit period, LSB first
// STOP      | sampling the stop bit, then delivering the byte or flagging a framing error
// WAIT_HIGH | stop bit was low; waiting for the line to return high
module uart_rx_latch #(
    parameter int clk_freq  = 50_000_000,
    parameter int baud      = 115200,
    parameter int data_bits = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_latch_if.slave bus
);
    localparam int cpb  = clk_freq / baud;
    localparam int half = cpb / 2;
    localparam int cw   = $clog2(cpb);
    localparam int bw   = $clog2(data_bits + 1);

    localparam logic [cw-1:0] baud_last = cw'(cpb - 1);
    localparam logic [cw-1:0] half_last = cw'(half - 1);
    localparam logic [bw-1:0] bits_last = bw'(data_bits - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t               state, state_nxt;
    logic [1:0]           sync_q;
    logic                 rxd_s;
    logic [cw-1:0]        baud_cnt, baud_nxt;
    logic [bw-1:0]        bit_cnt, bit_nxt;
    logic [data_bits-1:0] shift_q, shift_nxt;
    logic [data_bits-1:0] data_q, data_nxt;
    logic                 valid_q, valid_nxt;
    logic                 ovr_q, ovr_nxt;
    logic                 ferr_q, ferr_nxt;

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sync_q   <= 2'b11;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sync_q   <= {sync_q[0], bus.uart_rxd};
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift_q  <= shift_nxt;
            data_q   <= data_nxt;
            valid_q  <= valid_nxt;
            ovr_q    <= ovr_nxt;
            ferr_q   <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        data_nxt  = data_q;
        valid_nxt = valid_q;
        ovr_nxt   = ovr_q;
        ferr_nxt  = 1'b0;

        // Ack is resolved first so a byte finishing on the same cycle sees the slot free.
        if (valid_q && bus.rx_ack) begin
            valid_nxt = 1'b0;
            ovr_nxt   = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_nxt = START;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (baud_cnt == half_last) begin
                    baud_nxt  = '0;
                    state_nxt = rxd_s ? IDLE : DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = {rxd_s, shift_q[data_bits-1:1]};
                    if (bit_cnt == bits_last) state_nxt = STOP;
                    else                      bit_nxt   = bit_cnt + 1'b1;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == baud_last) begin
                    baud_nxt = '0;
                    if (rxd_s) begin
                        state_nxt = IDLE;
                        if (!valid_nxt) begin
                            data_nxt  = shift_q;
                            valid_nxt = 1'b1;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_busy      = (state != IDLE);
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_latch.sv
// Scoreboard bench for uart_rx_latch at CPB=10: expected bytes queued as frames are sent.
module tb_uart_rx_latch;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ferr_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_latch_if #(.data_bits(8)) bus ();

    uart_rx_latch #(
        .clk_freq (1_000_000),
        .baud     (100_000),
        .data_bits(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rx_frame_err) ferr_cnt++;
        if (bus.rx_valid && !prev_valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else                   check("rx_data_at_valid", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        end
        prev_valid = bus.rx_valid;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        bus.uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) begin
            bus.uart_rxd = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            bus.uart_rxd = 1'b0;
            repeat (3 * CPB) @(negedge clk);
            bus.uart_rxd = 1'b1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.rx_valid && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, bus.rx_valid}, 32'd1);
    endtask

    task automatic pulse_ack();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int f0;
        int busy_cnt;

        reset        = 1'b1;
        bus.uart_rxd = 1'b1;
        bus.rx_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_busy", {31'd0, bus.rx_busy}, 32'd0);
        check("reset_data", {24'd0, bus.rx_data}, 32'd0);
        check("reset_flags", {30'd0, bus.rx_frame_err, bus.rx_overrun}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single byte, held without ack
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_valid("t1_valid");
        repeat (20) @(negedge clk);
        check("t1_valid_held", {31'd0, bus.rx_valid}, 32'd1);
        check("t1_data", {24'd0, bus.rx_data}, 32'hA5);
        check("t1_overrun", {31'd0, bus.rx_overrun}, 32'd0);
        check("t1_ferr_cnt", ferr_cnt, 32'd0);

        // 2: ack clears valid, data stays
        pulse_ack();
        check("t2_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("t2_data", {24'd0, bus.rx_data}, 32'hA5);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        check("t2_ack_ignored", {31'd0, bus.rx_valid}, 32'd0);

        // 3: back-to-back frames, second one overruns
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        check("t3_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("t3_data", {24'd0, bus.rx_data}, 32'h3C);
        check("t3_overrun", {31'd0, bus.rx_overrun}, 32'd1);
        pulse_ack();
        check("t3_valid_after_ack", {31'd0, bus.rx_valid}, 32'd0);
        check("t3_overrun_after_ack", {31'd0, bus.rx_overrun}, 32'd0);

        // 4: framing error, then a good frame
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        repeat (6) @(negedge clk);
        check("t4_ferr_pulses", ferr_cnt - f0, 32'd1);
        check("t4_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("t4_data_kept", {24'd0, bus.rx_data}, 32'h3C);
        check("t4_busy", {31'd0, bus.rx_busy}, 32'd0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_valid("t4_next_valid");
        check("t4_next_data", {24'd0, bus.rx_data}, 32'h0F);
        pulse_ack();

        // 5: short glitch is rejected in START
        f0 = ferr_cnt;
        busy_cnt = 0;
        bus.uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        bus.uart_rxd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rx_busy) busy_cnt++;
        end
        check("t5_busy_bounded", {31'd0, (busy_cnt >= 1 && busy_cnt <= CPB / 2 + 1)}, 32'd1);
        check("t5_idle", {31'd0, bus.rx_busy}, 32'd0);
        check("t5_no_flags", {29'd0, bus.rx_valid, bus.rx_overrun, 1'b0} | (ferr_cnt - f0), 32'd0);

        // 6: reset in the middle of bit 4 of 0xFF
        bus.uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        bus.uart_rxd = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_busy", {31'd0, bus.rx_busy}, 32'd0);
        check("t6_reset_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("t6_reset_data", {24'd0, bus.rx_data}, 32'd0);
        check("t6_reset_flags", {30'd0, bus.rx_frame_err, bus.rx_overrun}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8 * CPB) @(negedge clk);
        check("t6_no_partial_valid", {31'd0, bus.rx_valid}, 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_valid("t6_next_valid");
        check("t6_next_data", {24'd0, bus.rx_data}, 32'h81);
        pulse_ack();
        repeat (5) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("total_frame_errors", ferr_cnt, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
